// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM-stage CPU port and an
// external loader/debug port; the CPU has priority, bounded by a starvation counter.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_address,
  input  logic [DATA_W-1:0] ext_write_data,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic [31:0]       stall_count,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
  logic [DATA_W-1:0] ext_rdata_reg, ext_rdata_next;
  logic              ext_rvalid_reg, ext_rvalid_next;
  logic [31:0]       stall_count_reg, stall_count_next;

  logic cpu_req;
  logic ext_force;
  logic ext_grant;
  logic cpu_grant;

  // Grant decision; reset suppresses both grants so nothing reaches the memory.
  always_comb begin
    cpu_req   = cpu_read | cpu_write;
    ext_force = (starve_cnt_reg == STARVE_LIM);
    ext_grant = ~reset & ext_req & (~cpu_req | ext_force);
    cpu_grant = ~reset & cpu_req & ~ext_grant;
  end

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = cpu_address;
    mem_write_data = cpu_write_data;
    if (ext_grant) begin
      mem_read       = ~ext_we;
      mem_write      = ext_we;
      mem_address    = ext_address;
      mem_write_data = ext_write_data;
    end else if (cpu_grant) begin
      // A simultaneous load and store from the CPU resolves to the store.
      mem_read  = cpu_read & ~cpu_write;
      mem_write = cpu_write;
    end
  end

  assign cpu_stall     = ~reset & cpu_req & ~cpu_grant;
  assign ext_gnt       = ext_grant;
  assign cpu_read_data = mem_read_data;
  assign ext_rdata     = ext_rdata_reg;
  assign ext_rvalid    = ext_rvalid_reg;
  assign stall_count   = stall_count_reg;

  always_comb begin
    starve_cnt_next = '0;
    if (cpu_grant && ext_req) begin
      starve_cnt_next = (starve_cnt_reg == STARVE_LIM) ? starve_cnt_reg
                                                       : starve_cnt_reg + CNT_W'(1);
    end

    ext_rvalid_next = ext_grant & ~ext_we;
    ext_rdata_next  = ext_rvalid_next ? mem_read_data : ext_rdata_reg;

    stall_count_next = stall_count_reg;
    if (cpu_stall && (stall_count_reg != 32'hFFFF_FFFF)) begin
      stall_count_next = stall_count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_reg  <= '0;
      ext_rdata_reg   <= '0;
      ext_rvalid_reg  <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      starve_cnt_reg  <= starve_cnt_next;
      ext_rdata_reg   <= ext_rdata_next;
      ext_rvalid_reg  <= ext_rvalid_next;
      stall_count_reg <= stall_count_next;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level model with its own copy of the memory contents.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_a, reset_b;
  logic        cpu_read, cpu_write, ext_req, ext_we;
  logic [31:0] cpu_address, cpu_write_data, ext_address, ext_write_data;

  logic [31:0] a_cpu_read_data, a_ext_rdata, a_stall_count, a_mem_address, a_mem_write_data, a_mem_read_data;
  logic        a_cpu_stall, a_ext_gnt, a_ext_rvalid, a_mem_read, a_mem_write;
  logic [31:0] b_cpu_read_data, b_ext_rdata, b_stall_count, b_mem_address, b_mem_write_data, b_mem_read_data;
  logic        b_cpu_stall, b_ext_gnt, b_ext_rvalid, b_mem_read, b_mem_write;

  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] init_mem [256];

  int passes = 0;
  int checks = 0;

  // Reference model state
  int          m_starve;
  logic [31:0] m_stall;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic [31:0] m_mem [256];
  logic        e_ext_gnt, e_cpu_g, e_cpu_stall, e_mem_read, e_mem_write;
  logic [31:0] e_addr, e_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut_a (
    .clk(clk), .reset(reset_a),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_write_data(cpu_write_data), .cpu_read_data(a_cpu_read_data), .cpu_stall(a_cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_address(ext_address), .ext_write_data(ext_write_data),
    .ext_gnt(a_ext_gnt), .ext_rdata(a_ext_rdata), .ext_rvalid(a_ext_rvalid),
    .stall_count(a_stall_count), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .mem_address(a_mem_address), .mem_write_data(a_mem_write_data), .mem_read_data(a_mem_read_data)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(0)) dut_b (
    .clk(clk), .reset(reset_b),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_write_data(cpu_write_data), .cpu_read_data(b_cpu_read_data), .cpu_stall(b_cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_address(ext_address), .ext_write_data(ext_write_data),
    .ext_gnt(b_ext_gnt), .ext_rdata(b_ext_rdata), .ext_rvalid(b_ext_rvalid),
    .stall_count(b_stall_count), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_address(b_mem_address), .mem_write_data(b_mem_write_data), .mem_read_data(b_mem_read_data)
  );

  // Behavioural data memories: combinational read, write at the clock edge.
  always @(posedge clk) begin
    if (pre_we) begin
      mem_a[pre_addr] <= pre_data;
      mem_b[pre_addr] <= pre_data;
    end else begin
      if (a_mem_write) mem_a[a_mem_address[7:0]] <= a_mem_write_data;
      if (b_mem_write) mem_b[b_mem_address[7:0]] <= b_mem_write_data;
    end
  end
  assign a_mem_read_data = mem_a[a_mem_address[7:0]];
  assign b_mem_read_data = mem_b[b_mem_address[7:0]];

  task automatic model_reset();
    m_starve = 0;
    m_stall  = 32'd0;
    m_rdata  = 32'd0;
    m_rvalid = 1'b0;
  endtask

  // Expected combinational behaviour for the current inputs.
  task automatic model_eval(input int smax, input logic rst);
    logic creq;
    creq        = cpu_read | cpu_write;
    e_ext_gnt   = !rst && ext_req && (!creq || m_starve >= smax);
    e_cpu_g     = !rst && creq && !e_ext_gnt;
    e_cpu_stall = !rst && creq && !e_cpu_g;
    if (e_ext_gnt) begin
      e_mem_write = ext_we;
      e_mem_read  = !ext_we;
      e_addr      = ext_address;
    end else begin
      e_mem_write = e_cpu_g && cpu_write;
      e_mem_read  = e_cpu_g && cpu_read && !cpu_write;
      e_addr      = cpu_address;
    end
    e_rd = m_mem[e_addr[7:0]];
  endtask

  // Effect of the clock edge on the model, using this cycle's expectations.
  task automatic model_clock(input int smax, input logic rst);
    if (rst) begin
      model_reset();
    end else begin
      m_rvalid = e_ext_gnt && !ext_we;
      if (m_rvalid) m_rdata = m_mem[ext_address[7:0]];
      if (e_mem_write) m_mem[e_addr[7:0]] = e_ext_gnt ? ext_write_data : cpu_write_data;
      m_starve = (e_cpu_g && ext_req) ? ((m_starve + 1 > smax) ? smax : m_starve + 1) : 0;
      if (e_cpu_stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    end
  endtask

  task automatic settle(input int smax, input logic rst);
    model_eval(smax, rst);
    #1;
  endtask

  task automatic advance(input int smax, input logic rst);
    @(posedge clk);
    model_clock(smax, rst);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_read = 0; cpu_write = 0; ext_req = 0; ext_we = 0;
    cpu_address = 0; cpu_write_data = 0; ext_address = 0; ext_write_data = 0;
  endtask

  task automatic pulse_reset_a();
    @(negedge clk);
    idle_inputs();
    reset_a = 1;
    settle(4, 1);
    advance(4, 1);
    @(negedge clk);
    reset_a = 0;
  endtask

  task automatic test_reset();
    reset_a = 1; reset_b = 1; pre_we = 0; pre_addr = 0; pre_data = 0;
    idle_inputs();
    for (int i = 0; i < 256; i++) init_mem[i] = $urandom;
    init_mem[8'h10] = 32'hDEADBEEF;
    init_mem[8'h30] = 32'hCAFEF00D;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pre_we = 1; pre_addr = 8'(i); pre_data = init_mem[i];
      m_mem[i] = init_mem[i];
    end
    @(negedge clk);
    pre_we = 0;
    model_reset();
    cpu_read = 1; cpu_write = 1; ext_req = 1; ext_we = 1; ext_address = 32'h44;
    #1;
    checks++; if (a_ext_gnt !== 1'b0) $display("FAIL reset_ext_gnt got=%b exp=0", a_ext_gnt); else passes++;
    checks++; if (a_cpu_stall !== 1'b0) $display("FAIL reset_cpu_stall got=%b exp=0", a_cpu_stall); else passes++;
    checks++; if ({a_mem_read, a_mem_write} !== 2'b00) $display("FAIL reset_mem_rw got=%b%b exp=00", a_mem_read, a_mem_write); else passes++;
    @(posedge clk); #1;
    checks++; if (a_ext_rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", a_ext_rvalid); else passes++;
    checks++; if (a_ext_rdata !== 32'd0) $display("FAIL reset_rdata got=%h exp=0", a_ext_rdata); else passes++;
    checks++; if (a_stall_count !== 32'd0) $display("FAIL reset_stall_count got=%0d exp=0", a_stall_count); else passes++;
    $display("reset: requests held high under reset, outputs quiet");
    @(negedge clk);
    idle_inputs();
    reset_a = 0;
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    cpu_read = 1; cpu_address = 32'h10;
    settle(4, 0);
    checks++; if (a_cpu_read_data !== 32'hDEADBEEF) $display("FAIL cpu_read_data got=%h exp=deadbeef", a_cpu_read_data); else passes++;
    checks++; if (a_cpu_stall !== 1'b0) $display("FAIL cpu_read_stall got=%b exp=0", a_cpu_stall); else passes++;
    checks++; if (a_mem_read !== 1'b1) $display("FAIL cpu_read_mem_read got=%b exp=1", a_mem_read); else passes++;
    $display("cpu_read: addr=10 data=%h", a_cpu_read_data);
    advance(4, 0);
    cpu_read = 0;
  endtask

  task automatic test_ext_write();
    @(negedge clk);
    idle_inputs();
    ext_req = 1; ext_we = 1; ext_address = 32'h20; ext_write_data = 32'h12345678;
    settle(4, 0);
    checks++; if (a_ext_gnt !== 1'b1) $display("FAIL ext_write_gnt got=%b exp=1", a_ext_gnt); else passes++;
    checks++; if (a_mem_write !== 1'b1) $display("FAIL ext_write_mem_write got=%b exp=1", a_mem_write); else passes++;
    checks++; if (a_mem_address !== 32'h20) $display("FAIL ext_write_addr got=%h exp=20", a_mem_address); else passes++;
    advance(4, 0);
    @(negedge clk);
    idle_inputs();
    cpu_read = 1; cpu_address = 32'h20;
    settle(4, 0);
    checks++; if (a_mem_write !== 1'b0) $display("FAIL ext_write_one_cycle got=%b exp=0", a_mem_write); else passes++;
    checks++; if (a_cpu_read_data !== 32'h12345678) $display("FAIL ext_write_readback got=%h exp=12345678", a_cpu_read_data); else passes++;
    $display("ext_write: addr=20 readback=%h", a_cpu_read_data);
    advance(4, 0);
  endtask

  task automatic test_ext_read();
    @(negedge clk);
    idle_inputs();
    ext_req = 1; ext_we = 0; ext_address = 32'h30;
    settle(4, 0);
    checks++; if (a_ext_gnt !== 1'b1) $display("FAIL ext_read_gnt got=%b exp=1", a_ext_gnt); else passes++;
    checks++; if (a_ext_rvalid !== 1'b0) $display("FAIL ext_read_rvalid_early got=%b exp=0", a_ext_rvalid); else passes++;
    advance(4, 0);
    checks++; if (a_ext_rvalid !== 1'b1) $display("FAIL ext_read_rvalid got=%b exp=1", a_ext_rvalid); else passes++;
    checks++; if (a_ext_rdata !== 32'hCAFEF00D) $display("FAIL ext_read_rdata got=%h exp=cafef00d", a_ext_rdata); else passes++;
    @(negedge clk);
    ext_req = 0;
    settle(4, 0);
    advance(4, 0);
    checks++; if (a_ext_rvalid !== 1'b0) $display("FAIL ext_read_rvalid_pulse got=%b exp=0", a_ext_rvalid); else passes++;
    checks++; if (a_ext_rdata !== 32'hCAFEF00D) $display("FAIL ext_read_rdata_hold got=%h exp=cafef00d", a_ext_rdata); else passes++;
    $display("ext_read: addr=30 rdata=%h", a_ext_rdata);
  endtask

  // Continuous contention: EXT wins every fifth cycle, one stall per round.
  task automatic test_starvation();
    pulse_reset_a();
    for (int i = 0; i < 15; i++) begin
      if (i != 0) @(negedge clk);
      cpu_read = 1; cpu_address = 32'($urandom_range(0, 255));
      ext_req = 1; ext_we = 0; ext_address = 32'($urandom_range(0, 255));
      settle(4, 0);
      checks++; if (a_ext_gnt !== (i % 5 == 4)) $display("FAIL starve_gnt cyc=%0d got=%b exp=%b", i, a_ext_gnt, (i % 5 == 4)); else passes++;
      checks++; if (a_cpu_stall !== (i % 5 == 4)) $display("FAIL starve_stall cyc=%0d got=%b exp=%b", i, a_cpu_stall, (i % 5 == 4)); else passes++;
      advance(4, 0);
      checks++; if (a_stall_count !== 32'((i + 1) / 5)) $display("FAIL starve_count cyc=%0d got=%0d exp=%0d", i, a_stall_count, (i + 1) / 5); else passes++;
      $display("starve cyc=%0d gnt=%b stall=%b count=%0d", i, a_ext_gnt, a_cpu_stall, a_stall_count);
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset_a();
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      reset_a = (i == 2);
      cpu_read = 1; cpu_address = 32'h10;
      ext_req = 1; ext_we = 0; ext_address = 32'h30;
      settle(4, reset_a);
      if (i == 2) begin
        checks++; if ({a_ext_gnt, a_cpu_stall} !== 2'b00) $display("FAIL midrst_quiet got=%b%b exp=00", a_ext_gnt, a_cpu_stall); else passes++;
      end else begin
        checks++; if (a_ext_gnt !== (i == 7)) $display("FAIL midrst_gnt cyc=%0d got=%b exp=%b", i, a_ext_gnt, (i == 7)); else passes++;
      end
      advance(4, reset_a);
      if (i == 2) begin
        checks++; if (a_ext_rvalid !== 1'b0) $display("FAIL midrst_rvalid got=%b exp=0", a_ext_rvalid); else passes++;
        checks++; if (a_stall_count !== 32'd0) $display("FAIL midrst_count got=%0d exp=0", a_stall_count); else passes++;
      end
      $display("reset_mid cyc=%0d rst=%b gnt=%b count=%0d", i, reset_a, a_ext_gnt, a_stall_count);
    end
    @(negedge clk);
    reset_a = 0;
    idle_inputs();
  endtask

  // STARVE_MAX = 0 instance: EXT always wins; DUT A is parked in reset meanwhile.
  task automatic test_starve_zero();
    logic [7:0] ea;
    @(negedge clk);
    idle_inputs();
    reset_a = 1;
    reset_b = 0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      ea = 8'($urandom);
      cpu_read = 1; cpu_address = 32'h10;
      ext_req = 1; ext_we = 0; ext_address = {24'd0, ea};
      #1;
      checks++; if (b_ext_gnt !== 1'b1) $display("FAIL zero_gnt cyc=%0d got=%b exp=1", i, b_ext_gnt); else passes++;
      checks++; if (b_cpu_stall !== 1'b1) $display("FAIL zero_stall cyc=%0d got=%b exp=1", i, b_cpu_stall); else passes++;
      checks++; if (b_cpu_read_data !== init_mem[ea]) $display("FAIL zero_mux cyc=%0d got=%h exp=%h", i, b_cpu_read_data, init_mem[ea]); else passes++;
      @(posedge clk); #1;
      checks++; if (b_stall_count !== 32'(i + 1)) $display("FAIL zero_count cyc=%0d got=%0d exp=%0d", i, b_stall_count, i + 1); else passes++;
      checks++; if (b_ext_rvalid !== 1'b1 || b_ext_rdata !== init_mem[ea]) $display("FAIL zero_rdata cyc=%0d got=%b/%h exp=1/%h", i, b_ext_rvalid, b_ext_rdata, init_mem[ea]); else passes++;
      $display("starve_zero cyc=%0d gnt=%b stall=%b count=%0d", i, b_ext_gnt, b_cpu_stall, b_stall_count);
    end
    @(negedge clk);
    idle_inputs();
    reset_b = 1;
    model_reset();
    @(negedge clk);
    reset_a = 0;
  endtask

  task automatic test_random();
    logic pend;
    pend = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cpu_read = ($urandom % 2) == 0; cpu_write = ($urandom % 3) == 0;
      cpu_address = $urandom; cpu_write_data = $urandom;
      if (!pend) begin
        ext_req = ($urandom % 3) == 0; ext_we = $urandom % 2;
        ext_address = $urandom; ext_write_data = $urandom;
      end else if (($urandom % 16) == 0) begin
        ext_req = 0;
      end
      settle(4, 0);
      checks++; if (a_ext_gnt !== e_ext_gnt) $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", i, a_ext_gnt, e_ext_gnt); else passes++;
      checks++; if (a_cpu_stall !== e_cpu_stall) $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, a_cpu_stall, e_cpu_stall); else passes++;
      checks++; if ({a_mem_read, a_mem_write} !== {e_mem_read, e_mem_write}) $display("FAIL rnd_rw cyc=%0d got=%b%b exp=%b%b", i, a_mem_read, a_mem_write, e_mem_read, e_mem_write); else passes++;
      checks++; if (a_mem_address !== e_addr) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, a_mem_address, e_addr); else passes++;
      checks++; if (a_cpu_read_data !== e_rd) $display("FAIL rnd_rdata_comb cyc=%0d got=%h exp=%h", i, a_cpu_read_data, e_rd); else passes++;
      if (e_mem_write) begin
        checks++; if (a_mem_write_data !== (e_ext_gnt ? ext_write_data : cpu_write_data)) $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", i, a_mem_write_data, (e_ext_gnt ? ext_write_data : cpu_write_data)); else passes++;
      end
      pend = ext_req && !e_ext_gnt;
      advance(4, 0);
      checks++; if (a_ext_rvalid !== m_rvalid) $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", i, a_ext_rvalid, m_rvalid); else passes++;
      checks++; if (a_ext_rdata !== m_rdata) $display("FAIL rnd_ext_rdata cyc=%0d got=%h exp=%h", i, a_ext_rdata, m_rdata); else passes++;
      checks++; if (a_stall_count !== m_stall) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, a_stall_count, m_stall); else passes++;
      $display("rnd cyc=%0d cpu=%b%b ext=%b%b gnt=%b stall=%b count=%0d", i, cpu_read, cpu_write, ext_req, ext_we, a_ext_gnt, a_cpu_stall, a_stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_ext_write();
    test_ext_read();
    test_starvation();
    test_reset_mid();
    test_starve_zero();
    pulse_reset_a();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
